// File: rtl/mcs51_bus_regs_if.sv
// 8051 multiplexed external-bus pins as seen by a bus slave.
// Host drives strobes/address/data-in; slave returns read data and the pad output enable.
interface mcs51_bus_regs_if;
    logic       cs_n;
    logic       ale;
    logic       r_n;
    logic       w_n;
    logic [7:0] abus;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       dbus_oe;

    modport master (
        output cs_n, ale, r_n, w_n, abus, dbus_in,
        input  dbus_out, dbus_oe
    );

    modport slave (
        input  cs_n, ale, r_n, w_n, abus, dbus_in,
        output dbus_out, dbus_oe
    );
endinterface

// File: rtl/mcs51_bus_regs.sv
// 8051 bus slave onto NUM_REGS x 8-bit config regs, STATUS snapshot and ERRCNT; readback under MCS51_BUS_RDBK_EN.
// Latency: pin edge to cfg_out/wr_stb/dbus_out effect is SYNC_STAGES+1 clocks.
// Backpressure: none; the host must honour minimum pulse widths of SYNC_STAGES+1 clocks.
module mcs51_bus_regs #(
    parameter int          NUM_REGS    = 16,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    mcs51_bus_regs_if.slave       bus,
    input  logic [7:0]            sts_in,
    output logic [8*NUM_REGS-1:0] cfg_out,
    output logic [NUM_REGS-1:0]   wr_stb
);
    localparam logic [19:0] PIN_IDLE = {4'b1111, 16'h0000};
    localparam logic [15:0] N16      = 16'(NUM_REGS);

    logic [19:0]            sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   armed_q;
    logic                   ale_d;
    logic                   w_n_d;
    logic                   s_cs_n, s_ale, s_r_n, s_w_n;
    logic [15:0]            s_addr;
    logic [7:0]             s_dat;
    logic                   sel, ale_fall, w_rise;
    logic [15:0]            addr_q;
    logic [15:0]            off;
    logic                   is_cfg, is_err;
    logic                   wr_cfg, wr_bad, err_clr, rd_bad;
    logic [7:0]             cfg_q [NUM_REGS];
    logic [7:0]             errcnt_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
            fill_q <= '0;
        end else begin
            sync_q[0] <= {bus.cs_n, bus.ale, bus.r_n, bus.w_n, bus.abus, bus.dbus_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign {s_cs_n, s_ale, s_r_n, s_w_n, s_addr} = sync_q[SYNC_STAGES-1];
    assign s_dat = s_addr[7:0];

    // A cycle already in flight at reset release is dropped: accept edges only
    // once the synchroniser has refilled and cs_n has been seen idle.
    always_ff @(posedge clock) begin
        if (rst) begin
            armed_q <= 1'b0;
            ale_d   <= 1'b1;
            w_n_d   <= 1'b1;
        end else begin
            ale_d <= s_ale;
            w_n_d <= s_w_n;
            if (fill_q[SYNC_STAGES-1] && s_cs_n) armed_q <= 1'b1;
        end
    end

    assign sel      = armed_q & ~s_cs_n;
    assign ale_fall = sel & ale_d & ~s_ale;
    assign w_rise   = sel & ~w_n_d & s_w_n;

    always_ff @(posedge clock) begin
        if (rst)           addr_q <= '0;
        else if (ale_fall) addr_q <= s_addr;
    end

    assign off     = addr_q - BASE_ADDR;
    assign is_cfg  = off < N16;
    assign is_err  = off == N16 + 16'd1;
    assign wr_cfg  = w_rise & is_cfg;
    assign err_clr = w_rise & is_err;
    assign wr_bad  = w_rise & ~is_cfg & ~is_err;

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
            wr_stb <= '0;
        end else begin
            wr_stb <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_cfg && off == 16'(i)) begin
                    cfg_q[i]  <= s_dat;
                    wr_stb[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cfg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) cfg_out[8*i +: 8] = cfg_q[i];
    end

    // Saturating error counter; a write to its own address clears it.
    always_ff @(posedge clock) begin
        if (rst)                                                   errcnt_q <= '0;
        else if (err_clr)                                          errcnt_q <= '0;
        else if ((wr_bad || rd_bad) && errcnt_q != 8'hFF)          errcnt_q <= errcnt_q + 8'd1;
    end

`ifdef MCS51_BUS_RDBK_EN
    logic       r_n_d, oe_q, r_fall, is_sts;
    logic [7:0] rd_dat, dout_q;

    assign is_sts = off == N16;
    assign r_fall = sel & r_n_d & ~s_r_n;
    assign rd_bad = r_fall & ~is_cfg & ~is_sts & ~is_err;

    always_comb begin
        rd_dat = 8'hFF;
        if (is_cfg) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (off == 16'(i)) rd_dat = cfg_q[i];
        end else if (is_sts) begin
            rd_dat = sts_in;
        end else if (is_err) begin
            rd_dat = errcnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_n_d  <= 1'b1;
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            r_n_d <= s_r_n;
            oe_q  <= sel & ~s_r_n;
            if (r_fall) dout_q <= rd_dat;
        end
    end

    // Registered term delays the rise by one clock; live terms drop it immediately.
    assign bus.dbus_out = dout_q;
    assign bus.dbus_oe  = oe_q & sel & ~s_r_n & s_w_n;
`else
    logic unused_rd;

    assign rd_bad       = 1'b0;
    assign bus.dbus_out = 8'h00;
    assign bus.dbus_oe  = 1'b0;
    assign unused_rd    = ^{s_r_n, sts_in};
`endif
endmodule

// File: tb/tb_mcs51_bus_regs.sv
// Directed bench for mcs51_bus_regs at default parameters (16 regs, base 0, 2 sync stages).
// Read checks adapt to MCS51_BUS_RDBK_EN; in the write-only build ERRCNT is observed hierarchically.
module tb_mcs51_bus_regs;
    localparam int HOLD = 4;
`ifdef MCS51_BUS_RDBK_EN
    localparam bit RDBK = 1'b1;
`else
    localparam bit RDBK = 1'b0;
`endif

    logic         clock;
    logic         rst;
    logic [7:0]   sts_in;
    logic [127:0] cfg_out;
    logic [15:0]  wr_stb;

    mcs51_bus_regs_if bus ();

    mcs51_bus_regs #(
        .NUM_REGS   (16),
        .BASE_ADDR  (16'h0000),
        .SYNC_STAGES(2)
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .bus    (bus),
        .sts_in (sts_in),
        .cfg_out(cfg_out),
        .wr_stb (wr_stb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0]  stb_hist [4];
    logic [127:0] cfg_hist [4];
    logic         oe_hist  [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic addr_phase(input logic [15:0] a);
        bus.cs_n    = 1'b0;
        bus.abus    = a[15:8];
        bus.dbus_in = a[7:0];
        bus.ale     = 1'b1;
        step(HOLD);
        bus.ale = 1'b0;
        step(HOLD);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr_phase(a);
        bus.dbus_in = d;
        step(HOLD);
        bus.w_n = 1'b0;
        step(HOLD);
        bus.w_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            stb_hist[k] = wr_stb;
            cfg_hist[k] = cfg_out;
        end
        @(negedge clock);
        bus.cs_n = 1'b1;
        step(HOLD);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic oe_after);
        addr_phase(a);
        bus.r_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            oe_hist[k] = bus.dbus_oe;
        end
        @(negedge clock);
        d = bus.dbus_out;
        bus.r_n = 1'b1;
        step(HOLD);
        oe_after = bus.dbus_oe;
        bus.cs_n = 1'b1;
        step(HOLD);
    endtask

    task automatic get_errcnt(output logic [7:0] v);
        logic oe_x;
`ifdef MCS51_BUS_RDBK_EN
        bus_read(16'd17, v, oe_x);
`else
        oe_x = 1'b0;
        v    = dut.errcnt_q;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]   rd;
        logic         oe_after;
        logic [127:0] acc_cfg;
        logic         acc_oe;
        logic [15:0]  acc_stb;

        rst         = 1'b1;
        sts_in      = 8'hA5;
        bus.cs_n    = 1'b1;
        bus.ale     = 1'b0;
        bus.r_n     = 1'b1;
        bus.w_n     = 1'b1;
        bus.abus    = 8'h00;
        bus.dbus_in = 8'h00;
        step(4);
        rst = 1'b0;

        acc_cfg = '0; acc_oe = 1'b0; acc_stb = '0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            acc_cfg |= cfg_out;
            acc_oe  |= bus.dbus_oe;
            acc_stb |= wr_stb;
        end
        @(negedge clock);
        chk("idle_cfg", acc_cfg[31:0] | acc_cfg[63:32] | acc_cfg[95:64] | acc_cfg[127:96], 32'h0);
        chk("idle_oe", {31'h0, acc_oe}, 32'h0);
        chk("idle_stb", {16'h0, acc_stb}, 32'h0);
        chk("idle_dout", {24'h0, bus.dbus_out}, 32'h0);

        bus_write(16'd8, 8'd10);
        chk("w8_stb_e2", {16'h0, stb_hist[1]}, 32'h0);
        chk("w8_stb_e3", {16'h0, stb_hist[2]}, 32'h0100);
        chk("w8_stb_e4", {16'h0, stb_hist[3]}, 32'h0);
        chk("w8_cfg_e2", {24'h0, cfg_hist[1][71:64]}, 32'd0);
        chk("w8_cfg_e3", {24'h0, cfg_hist[2][71:64]}, 32'd10);
        bus_write(16'd9, 8'd30);
        chk("w9_stb_e2", {16'h0, stb_hist[1]}, 32'h0);
        chk("w9_stb_e3", {16'h0, stb_hist[2]}, 32'h0200);
        chk("w9_stb_e4", {16'h0, stb_hist[3]}, 32'h0);
        chk("w9_cfg", {24'h0, cfg_out[79:72]}, 32'd30);
        chk("w9_keep8", {24'h0, cfg_out[71:64]}, 32'd10);

        bus_write(16'd0, 8'd1);
        bus_write(16'd1, 8'd2);
        bus_write(16'd2, 8'd3);
        chk("w012_cfg", {8'h0, cfg_out[23:0]}, 32'h030201);
        bus_read(16'd1, rd, oe_after);
        chk("r1_oe_e2", {31'h0, oe_hist[1]}, 32'h0);
        chk("r1_oe_e3", {31'h0, oe_hist[2]}, {31'h0, RDBK});
        chk("r1_dat", {24'h0, rd}, RDBK ? 32'd2 : 32'd0);
        chk("r1_oe_off", {31'h0, oe_after}, 32'h0);

        bus_write(16'h0100, 8'h55);
        chk("oor_w_stb", {16'h0, stb_hist[2]}, 32'h0);
        chk("oor_w_cfg_lo", cfg_out[31:0], 32'h00030201);
        chk("oor_w_cfg_hi", cfg_out[95:64], 32'h00001E0A);
        bus_read(16'h0100, rd, oe_after);
        chk("oor_r_dat", {24'h0, rd}, RDBK ? 32'hFF : 32'h0);
        bus_read(16'd16, rd, oe_after);
        chk("sts_r_dat", {24'h0, rd}, RDBK ? 32'hA5 : 32'h0);
        get_errcnt(rd);
        chk("errcnt_2", {24'h0, rd}, RDBK ? 32'd2 : 32'd1);
        bus_write(16'd17, 8'h00);
        chk("errclr_stb", {16'h0, stb_hist[2]}, 32'h0);
        get_errcnt(rd);
        chk("errcnt_clr", {24'h0, rd}, 32'd0);

        for (int i = 0; i < 260; i++) bus_write(16'h0200 + 16'(i), 8'(i));
        get_errcnt(rd);
        chk("errcnt_sat", {24'h0, rd}, 32'd255);
        chk("sat_cfg_lo", cfg_out[31:0], 32'h00030201);

        addr_phase(16'd3);
        bus.dbus_in = 8'h77;
        step(HOLD);
        bus.w_n = 1'b0;
        step(HOLD);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(6);
        bus.w_n = 1'b1;
        acc_stb = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            acc_stb |= wr_stb;
        end
        @(negedge clock);
        bus.cs_n = 1'b1;
        step(HOLD);
        chk("rst_mid_stb", {16'h0, acc_stb}, 32'h0);
        chk("rst_mid_reg3", {24'h0, cfg_out[31:24]}, 32'h0);
        chk("rst_cfg_clr", cfg_out[95:64], 32'h0);
        get_errcnt(rd);
        chk("rst_errcnt", {24'h0, rd}, 32'd0);

        bus_write(16'd3, 8'h42);
        chk("post_rst_stb", {16'h0, stb_hist[2]}, 32'h0008);
        chk("post_rst_reg3", {24'h0, cfg_out[31:24]}, 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mcs51_bus_regs.md
# mcs51_bus_regs

Parametrised 8051 external-bus slave that decodes the multiplexed address/data cycle (cs_n, ale, r_n, w_n, abus, dbus) into a configuration register file with write strobes, readback, a status snapshot register and an access-error counter. It sits between the host CPU pins and the chip's datapath: filter coefficients, filter mask and clock presets, replacing the write-only decode with a generic N-register block. All bus pins are asynchronous to `clock` and are synchronised internally.

## Interface
- `NUM_REGS`, 16, number of read/write 8-bit config registers (1..64)
- `BASE_ADDR`, 16'h0000, 16-bit address of register 0
- `SYNC_STAGES`, 2, synchroniser depth on bus pins (2..3)
- `clock`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cs_n`  in  1  chip select, active low
- `ale`  in  1  address latch enable; falling edge latches address
- `r_n`  in  1  read strobe, active low
- `w_n`  in  1  write strobe, active low; rising edge commits write
- `abus`  in  8  address high byte
- `dbus_in`  in  8  data bus input (address low byte during ale)
- `dbus_out`  out  8  read data
- `dbus_oe`  out  1  data bus output enable (pad tristate control)
- `sts_in`  in  8  live status from datapath
- `cfg_out`  out  8*NUM_REGS  flattened register file, reg i at [8i+7:8i]
- `wr_stb`  out  NUM_REGS  one-cycle pulse per register on committed write

## Operation
- Every bus pin passes through `SYNC_STAGES` flops, then one edge-detect flop. Synchroniser flops reset to idle level (cs_n/ale/r_n/w_n = 1) so no spurious edge follows reset.
- ale falling (synced) with cs_n low: latch addr = {abus, dbus_in} (synced values).
- Decode: off = addr - BASE_ADDR (16-bit, wraps). off < NUM_REGS → config reg; off == NUM_REGS → STATUS (read-only); off == NUM_REGS+1 → ERRCNT (read-only, write clears to 0); else out-of-range.
- w_n rising with cs_n low: write synced dbus_in to decoded reg, pulse matching `wr_stb` bit. Write to STATUS or out-of-range: ignored, ERRCNT increments.
- r_n falling with cs_n low: capture read data into `dbus_out`; `dbus_oe` = 1 while synced r_n and cs_n both low. Config reg returns its value; STATUS returns `sts_in` sampled that cycle; ERRCNT returns counter; out-of-range returns 8'hFF and increments ERRCNT.
- ERRCNT: 8-bit, saturates at 255, never wraps.
- Edges with cs_n high: ignored entirely, no counter change.
- r_n and w_n both low (synced): `dbus_oe` forced 0; w_n rising still commits normally.
- ale falling while w_n low: address updates; pending write uses latest address.
- Reset mid-transaction: cycle aborted, no partial write.

## Timing
- Reset values: `cfg_out` all 0, `wr_stb` 0, `dbus_out` 8'h00, `dbus_oe` 0, latched addr 0, ERRCNT 0.
- Pin-to-effect latency = SYNC_STAGES+1 cycles: w_n rising at pin → `cfg_out`/`wr_stb` update on clock edge SYNC_STAGES+1 later (3 cycles at default).
- `dbus_oe` rises SYNC_STAGES+1 cycles after r_n falls, drops SYNC_STAGES cycles after r_n or cs_n rises.
- Bus pulse minimum: each level of ale, r_n, w_n, cs_n held ≥ SYNC_STAGES+1 clocks; dbus_in stable from SYNC_STAGES before w_n rising until SYNC_STAGES after.
- `wr_stb` exactly one cycle wide, coincident with `cfg_out` change.

## Configuration
- `MCS51_BUS_RDBK_EN` defined: read path, STATUS and read-side ERRCNT accounting implemented as above.
- Not defined: write-only block; `dbus_oe` and `dbus_out` tied to 0, r_n ignored, ERRCNT counts only bad writes (still write-clearable, not readable).

## Test plan
- Reset then no bus activity 50 cycles → `cfg_out`=0, `dbus_oe`=0, `wr_stb`=0 throughout.
- Write 8'd10 to addr 16'd8, then 8'd30 to 16'd9 (BASE 0) → cfg reg8=10, reg9=30, one `wr_stb[8]` then one `wr_stb[9]` pulse, each 3 cycles after w_n rising.
- Write 8'd1..8'd3 to 0..2, read back addr 1 → `dbus_oe`=1 during r_n low, `dbus_out`=8'd2.
- Write to 16'h0100 and read 16'h0100 → no cfg change, read returns 8'hFF, ERRCNT (addr 17) reads 2; write ERRCNT → reads 0.
- 260 out-of-range writes → ERRCNT reads 255.
- Assert `rst` while w_n low mid-write to addr 3, release, w_n rises → reg3 stays 0, no `wr_stb`.
